// File: rtl/alu_addsub_mc.sv
// Multi-cycle adder/subtractor: adds one SLICE-bit slice per clock, LSB first,
// behind a valid/ready handshake on both the operand and the result side.
module alu_addsub_mc #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] rd,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  // WIDTH must be a whole multiple of SLICE.
  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, rd_q, rd_d;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, overflow_q, zero_q;

  logic [SLICE-1:0] a_slice, b_slice;
  logic [SLICE:0]   slice_sum;
  logic             last_slice;
  logic             msb_carry_in;
  int               slice_lo;

  // Slice datapath: the stored carry doubles as carry-in, so on accept it
  // holds sub and completes the two's-complement negation of rs2.
  always_comb begin
    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    slice_lo     = int'(cnt_q) * SLICE;
    a_slice      = a_q[slice_lo +: SLICE];
    b_slice      = b_q[slice_lo +: SLICE];
    slice_sum    = {1'b0, a_slice} + {1'b0, b_slice} + {{SLICE{1'b0}}, carry_q};
    last_slice   = (cnt_q == CW'(N - 1));
    rd_d         = rd_q;
    rd_d[slice_lo +: SLICE] = slice_sum[SLICE-1:0];
    msb_carry_in = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ slice_sum[SLICE-1];
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (in_valid)   state_d = CALC;
      CALC: if (last_slice) state_d = DONE;
      DONE: if (out_ready)  state_d = IDLE;
      default:              state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: these are plain registers, so clearing them on reset is cheap and keeps outputs defined.
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= rs1;
            b_q     <= rs2 ^ {WIDTH{sub}};
            carry_q <= sub;
            cnt_q   <= '0;
          end
        end
        CALC: begin
          rd_q    <= rd_d;
          carry_q <= slice_sum[SLICE];
          cnt_q   <= cnt_q + CW'(1);
          if (last_slice) begin
            overflow_q <= msb_carry_in ^ slice_sum[SLICE];
            zero_q     <= (rd_d == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign rd        = rd_q;
  assign carry     = carry_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_alu_addsub_mc.sv
// Randomized scoreboard bench for alu_addsub_mc: stimulus pushes expected
// results from an arithmetic reference model, a negedge monitor compares them.
module tb_alu_addsub_mc;

  localparam int W = 32;
  localparam int S = 8;
  localparam int N = W / S;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, sub, out_valid, out_ready;
  logic         carry, overflow, zero;
  logic [W-1:0] rs1, rs2, rd;

  typedef struct packed {
    logic [W-1:0] rd;
    logic         carry;
    logic         overflow;
    logic         zero;
  } res_t;

  res_t exp_q[$];
  int   acc_q[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  alu_addsub_mc #(.WIDTH(W), .SLICE(S)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .rs1(rs1), .rs2(rs2), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .rd(rd), .carry(carry), .overflow(overflow),
    .zero(zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "simulation timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Reference: plain unsigned/signed arithmetic, no slicing.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    res_t   r;
    longint sa, sb, sr;
    logic [W:0] wide;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (s) begin
      r.rd    = a - b;
      r.carry = (a >= b);
      sr      = sa - sb;
    end else begin
      wide    = {1'b0, a} + {1'b0, b};
      r.rd    = wide[W-1:0];
      r.carry = wide[W];
      sr      = sa + sb;
    end
    r.overflow = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    r.zero     = (r.rd == '0);
    return r;
  endfunction

  // Monitor: compares every presented result (so stalls prove stability),
  // pops on handshake, and checks accept-to-valid latency on each rise.
  initial begin
    logic prev_valid;
    res_t e;
    int   lat;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && out_valid) begin
        if (!prev_valid && acc_q.size() > 0) begin
          lat = cyc - acc_q.pop_front();
          check("latency", 64'(lat), 64'(N));
        end
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL spurious_out_valid: got out_valid=1 rd=%0h, required no result", rd);
        end else begin
          e = exp_q[0];
          check("rd", 64'(rd), 64'(e.rd));
          check("carry", 64'(carry), 64'(e.carry));
          check("overflow", 64'(overflow), 64'(e.overflow));
          check("zero", 64'(zero), 64'(e.zero));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      prev_valid = !rst && out_valid;
    end
  end

  task automatic wait_in_ready();
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL in_ready_timeout: got in_ready=0, required 1");
    end
  endtask

  // Called and returns at posedge+1. hold = DONE cycles with out_ready low.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input int hold);
    int n;
    rs1 = a; rs2 = b; sub = s; in_valid = 1'b1;
    wait_in_ready();
    @(posedge clk); #1;
    exp_q.push_back(model(a, b, s));
    acc_q.push_back(cyc);
    in_valid  = (hold > 0);
    rs1       = $urandom;
    rs2       = $urandom;
    sub       = 1'($urandom);
    out_ready = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid) begin
      vectors++;
      miscompares++;
      $display("FAIL out_valid_timeout: got out_valid=0, required 1");
    end
    for (int i = 0; i < hold; i++) begin
      check("in_ready_busy", 64'(in_ready), 64'd0);
      rs1 = $urandom; rs2 = $urandom;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("in_ready_after", 64'(in_ready), 64'd1);
    check("out_valid_after", 64'(out_valid), 64'd0);
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] corners [6];
    corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_00FF};
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sub = 1'b0;
    rs1 = '0; rs2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_rd", 64'(rd), 64'd0);
    check("rst_flags", 64'({carry, overflow, zero}), 64'd0);
    rst = 1'b0;

    issue(32'd1, 32'd1, 1'b0, 0);
    issue(32'hFFFF_FFFF, 32'd2, 1'b0, 0);
    issue(32'h7FFF_FFFF, 32'd1, 1'b0, 0);
    issue(32'd10, 32'd10, 1'b1, 0);
    issue(32'd10, 32'd21, 1'b1, 0);
    issue(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 5);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1);
    issue(32'hFFFF_FFFF, 32'd1, 1'b0, 0);
    issue(32'd0, 32'd1, 1'b1, 0);
    issue(32'h8000_0000, 32'd1, 1'b1, 2);

    // Abort: reset lands on the second CALC cycle; nothing may come out.
    rs1 = 32'd5; rs2 = 32'd6; sub = 1'b0; in_valid = 1'b1;
    wait_in_ready();
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_rd", 64'(rd), 64'd0);
    check("abort_flags", 64'({carry, overflow, zero}), 64'd0);
    repeat (8) @(posedge clk);
    #1;
    issue(32'd1, 32'd1, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      issue(pick(), pick(), 1'($urandom), $urandom_range(0, 3));
    end

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
